cpu_io: RTL

CPU_IO -- requirements
Module: cpu_io

---
 rtl/cpu_io_pkg.sv | 20 ++
 rtl/io_fifo.sv | 51 +++++
 rtl/cpu_io.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants and address-decode helpers for the CPU I/O bridge.
// Status word layout: held flags in the low bits, FIFO-full flags directly above them.
package cpu_io_pkg;

  localparam int STAT_HELD_LSB = 0;

  function automatic int stat_full_lsb(input int num_ch);
    return num_ch;
  endfunction

  // The bit just above the channel index selects the status word.
  function automatic logic addr_is_status(input logic [7:0] addr, input int ch_bits);
    return addr[ch_bits];
  endfunction

  function automatic logic [7:0] addr_chan(input logic [7:0] addr, input int ch_bits);
    return addr & ((8'd1 << ch_bits) - 8'd1);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Output FIFO with first-word fall-through: 0-cycle head visibility, 1-cycle push-to-head.
// Backpressure: the caller must gate push on full (unless popping) and pop on empty.
module io_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cpu_io.sv
// CPU-facing bridge: writes feed per-channel output FIFOs, reads drain per-channel input holding registers.
// Read data registered (1 cycle); cpu_stall is combinational when the target FIFO is full or the holding register empty.
module cpu_io
  import cpu_io_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NUM_CH):0]    cpu_addr,
  input  logic                       cpu_wr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_rd,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_stall,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic [NUM_CH-1:0]          out_valid,
  input  logic [NUM_CH-1:0]          out_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready
);

  localparam int CW = $clog2(NUM_CH);

  logic              addr_st;
  logic [CW-1:0]     addr_ch;
  logic              wr_en;
  logic              rd_en;
  logic              wr_stall;
  logic              rd_stall;
  logic              rd_ch_acc;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] held;
  logic [NUM_CH-1:0] rd_sel;
  logic [NUM_CH-1:0] capture;
  logic [DATA_W-1:0] hold_reg [NUM_CH];
  logic [DATA_W-1:0] status_word;

  assign addr_st = addr_is_status(8'(cpu_addr), CW);
  assign addr_ch = CW'(addr_chan(8'(cpu_addr), CW));

  // A write always takes priority, so a read only counts when no write is present.
  assign wr_en     = cpu_wr & ~addr_st;
  assign rd_en     = cpu_rd & ~cpu_wr;
  assign wr_stall  = wr_en & fifo_full[addr_ch] & ~pop[addr_ch];
  assign rd_stall  = rd_en & ~addr_st & ~held[addr_ch];
  assign rd_ch_acc = rd_en & ~addr_st & held[addr_ch];
  assign cpu_stall = wr_stall | rd_stall;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pop[i]       = ~fifo_empty[i] & out_ready[i];
    assign push[i]      = wr_en & ~wr_stall & (addr_ch == CW'(i));
    assign rd_sel[i]    = rd_ch_acc & (addr_ch == CW'(i));
    assign in_ready[i]  = ~held[i] | rd_sel[i];
    assign capture[i]   = in_valid[i] & in_ready[i];
    assign out_valid[i] = ~fifo_empty[i];

    io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .wdata (cpu_wdata),
      .pop   (pop[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .head  (out_data[i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    status_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      status_word[STAT_HELD_LSB + i]         = held[i];
      status_word[stat_full_lsb(NUM_CH) + i] = fifo_full[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= '0;
      cpu_rdata <= '0;
    end else begin
      // A refill on the same edge as a read keeps the register occupied.
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i])     held[i] <= 1'b1;
        else if (rd_sel[i]) held[i] <= 1'b0;
      end
      if (rd_en & addr_st) cpu_rdata <= status_word;
      else if (rd_ch_acc)  cpu_rdata <= hold_reg[addr_ch];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (capture[i]) hold_reg[i] <= in_data[i*DATA_W +: DATA_W];
    end
  end

endmodule
